// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and counter width.
package mdu_unit_pkg;

   typedef enum logic [2:0] {
      MduMult  = 3'd0,
      MduMultu = 3'd1,
      MduDiv   = 3'd2,
      MduDivu  = 3'd3,
      MduMthi  = 3'd4,
      MduMtlo  = 3'd5
   } mdu_op_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage MDU bus: request/operands from the pipeline, Busy and HI/LO read path back.
interface mdu_unit_if;

   logic        Start;
   logic        MoveTo;
   logic        Cancel;
   logic [2:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        ReadHi;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] ReadData;

   modport master (
      output Start, MoveTo, Cancel, MDUOp, A, B, ReadHi,
      input  Busy, HI, LO, ReadData
   );

   modport slave (
      input  Start, MoveTo, Cancel, MDUOp, A, B, ReadHi,
      output Busy, HI, LO, ReadData
   );

endinterface

// File: rtl/mdu_unit_arith.sv
// Combinational multiply/divide datapath producing the {hi,lo} result for a latched op.
module mdu_arith
   import mdu_unit_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div_by_zero
);

   logic        w_signed;
   logic        w_is_div;
   logic [63:0] w_prod;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;

   always_comb begin
      w_signed = (i_op == MduMult) || (i_op == MduDiv);
      w_is_div = (i_op == MduDiv) || (i_op == MduDivu);

      // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
      if (w_signed) begin
         w_prod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
      end else begin
         w_prod = {32'b0, i_a} * {32'b0, i_b};
      end

      w_a_mag = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
      w_b_mag = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

      if (w_b_mag != 32'd0) begin
         w_q_mag = w_a_mag / w_b_mag;
         w_r_mag = w_a_mag % w_b_mag;
      end else begin
         w_q_mag = 32'd0;
         w_r_mag = 32'd0;
      end

      o_div_by_zero = w_is_div && (i_b == 32'd0);

      if (w_is_div) begin
         // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, positive sign, no negate.
         o_lo = (w_signed && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
         o_hi = (w_signed && i_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;
      end else begin
         o_lo = w_prod[31:0];
         o_hi = w_prod[63:32];
      end
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MDU with HI/LO registers; owns the latency counter, operand latch and moves.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic      clk,
   input  logic      reset_n,
   mdu_unit_if.slave bus
);

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic [CNT_W-1:0] w_cnt_d;
   logic [2:0]       w_op_d;
   logic [31:0]      w_a_d;
   logic [31:0]      w_b_d;
   logic [31:0]      w_hi_d;
   logic [31:0]      w_lo_d;

   logic             w_busy;
   logic             w_move;
   logic             w_start;
   logic             w_is_div_op;
   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;
   logic             w_div_by_zero;

   mdu_arith u_arith (
      .i_op          (r_op),
      .i_a           (r_a),
      .i_b           (r_b),
      .o_hi          (w_res_hi),
      .o_lo          (w_res_lo),
      .o_div_by_zero (w_div_by_zero)
   );

   assign w_busy      = (r_cnt != '0);
   assign w_move      = bus.MoveTo && !bus.Cancel &&
                        ((bus.MDUOp == MduMthi) || (bus.MDUOp == MduMtlo));
   // A move in the same cycle wins; reserved opcodes fall out of the range check.
   assign w_start     = bus.Start && !bus.Cancel && !w_busy && !w_move && (bus.MDUOp <= 3'd3);
   assign w_is_div_op = (bus.MDUOp == MduDiv) || (bus.MDUOp == MduDivu);

   always_comb begin
      w_cnt_d = r_cnt;
      w_op_d  = r_op;
      w_a_d   = r_a;
      w_b_d   = r_b;
      w_hi_d  = r_hi;
      w_lo_d  = r_lo;

      if (w_move) begin
         w_cnt_d = '0;
         if (bus.MDUOp == MduMthi) begin
            w_hi_d = bus.A;
         end else begin
            w_lo_d = bus.A;
         end
      end else if (w_start) begin
         w_cnt_d = w_is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         w_op_d  = bus.MDUOp;
         w_a_d   = bus.A;
         w_b_d   = bus.B;
      end else if (w_busy) begin
         w_cnt_d = r_cnt - 1'b1;
         if ((r_cnt == CNT_W'(1)) && !w_div_by_zero) begin
            w_hi_d = w_res_hi;
            w_lo_d = w_res_lo;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else begin
         r_cnt <= w_cnt_d;
         r_op  <= w_op_d;
         r_a   <= w_a_d;
         r_b   <= w_b_d;
         r_hi  <= w_hi_d;
         r_lo  <= w_lo_d;
      end
   end

   assign bus.Busy     = w_busy;
   assign bus.HI       = r_hi;
   assign bus.LO       = r_lo;
   assign bus.ReadData = bus.ReadHi ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latencies, results, moves, cancel, abort and async reset.
module tb_mdu_unit;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   int   n;

   mdu_unit_if bus ();

   mdu_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic op_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start = 1'b1;
      bus.MDUOp = op;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic op_move(input logic [2:0] op, input logic [31:0] a, input logic cancel);
      bus.MoveTo = 1'b1;
      bus.Cancel = cancel;
      bus.MDUOp  = op;
      bus.A      = a;
      tick();
      bus.MoveTo = 1'b0;
      bus.Cancel = 1'b0;
   endtask

   // Counts sampled Busy cycles, bounded so a stuck Busy still reaches the summary.
   task automatic wait_busy(output int cycles);
      cycles = 0;
      while (bus.Busy && cycles < 40) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      bus.Start  = 1'b0;
      bus.MoveTo = 1'b0;
      bus.Cancel = 1'b0;
      bus.MDUOp  = 3'd0;
      bus.A      = 32'd0;
      bus.B      = 32'd0;
      bus.ReadHi = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, bus.Busy}, 32'd0);
      check("reset_hi", bus.HI, 32'd0);
      check("reset_lo", bus.LO, 32'd0);
      #2 reset_n = 1'b1;
      tick();

      // MULT -2 * 3
      op_start(3'd0, 32'hFFFF_FFFE, 32'd3);
      wait_busy(n);
      check("mult_busy_cycles", 32'(n), 32'd5);
      check("mult_hi", bus.HI, 32'hFFFF_FFFF);
      check("mult_lo", bus.LO, 32'hFFFF_FFFA);
      bus.ReadHi = 1'b1;
      #1 check("readdata_hi", bus.ReadData, 32'hFFFF_FFFF);
      bus.ReadHi = 1'b0;
      #1 check("readdata_lo", bus.ReadData, 32'hFFFF_FFFA);

      // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
      op_start(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_busy(n);
      check("multu_busy_cycles", 32'(n), 32'd5);
      check("multu_hi", bus.HI, 32'h0000_0002);
      check("multu_lo", bus.LO, 32'hFFFF_FFFA);

      // DIV -7 / 2 -> q=-3, r=-1
      op_start(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_busy(n);
      check("div_busy_cycles", 32'(n), 32'd10);
      check("div_lo", bus.LO, 32'hFFFF_FFFD);
      check("div_hi", bus.HI, 32'hFFFF_FFFF);

      // Preload via moves, then DIVU by zero leaves HI/LO alone
      op_move(3'd4, 32'h11, 1'b0);
      check("mthi_hi", bus.HI, 32'h11);
      check("mthi_lo_kept", bus.LO, 32'hFFFF_FFFD);
      op_move(3'd5, 32'h22, 1'b0);
      check("mtlo_lo", bus.LO, 32'h22);
      op_start(3'd3, 32'd7, 32'd0);
      wait_busy(n);
      check("divu0_busy_cycles", 32'(n), 32'd10);
      check("divu0_hi", bus.HI, 32'h11);
      check("divu0_lo", bus.LO, 32'h22);

      // MTLO on cycle 3 of a MULT aborts it
      op_start(3'd0, 32'd5, 32'd6);
      tick();
      tick();
      op_move(3'd5, 32'h1234, 1'b0);
      check("abort_busy", {31'b0, bus.Busy}, 32'd0);
      check("abort_lo", bus.LO, 32'h1234);
      check("abort_hi", bus.HI, 32'h11);
      repeat (10) tick();
      check("abort_lo_late", bus.LO, 32'h1234);
      check("abort_hi_late", bus.HI, 32'h11);

      // Cancel masks Start and MoveTo
      bus.Cancel = 1'b1;
      op_start(3'd0, 32'd5, 32'd6);
      bus.Cancel = 1'b0;
      check("cancel_start_busy", {31'b0, bus.Busy}, 32'd0);
      repeat (6) tick();
      check("cancel_start_hi", bus.HI, 32'h11);
      check("cancel_start_lo", bus.LO, 32'h1234);
      op_move(3'd4, 32'hBEEF, 1'b1);
      check("cancel_mthi_hi", bus.HI, 32'h11);

      // Start while Busy is ignored: MULT 100*7 completes, DIVU 9/2 never runs
      op_start(3'd0, 32'd100, 32'd7);
      bus.Start = 1'b1;
      bus.MDUOp = 3'd3;
      bus.A     = 32'd9;
      bus.B     = 32'd2;
      tick();
      bus.Start = 1'b0;
      wait_busy(n);
      check("restart_busy_cycles", 32'(n + 1), 32'd5);
      check("restart_lo", bus.LO, 32'h0000_02BC);
      check("restart_hi", bus.HI, 32'd0);
      tick();
      check("restart_idle", {31'b0, bus.Busy}, 32'd0);

      // DIV 0x80000000 / -1
      op_start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_busy(n);
      check("divovf_lo", bus.LO, 32'h8000_0000);
      check("divovf_hi", bus.HI, 32'd0);

      // Reserved opcodes change nothing
      op_move(3'd6, 32'hDEAD, 1'b0);
      check("rsvd_move_hi", bus.HI, 32'd0);
      check("rsvd_move_lo", bus.LO, 32'h8000_0000);
      op_start(3'd7, 32'd3, 32'd3);
      check("rsvd_start_busy", {31'b0, bus.Busy}, 32'd0);

      // Async reset mid-DIV
      op_start(3'd2, 32'd100, 32'd7);
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("rst_busy", {31'b0, bus.Busy}, 32'd0);
      check("rst_hi", bus.HI, 32'd0);
      check("rst_lo", bus.LO, 32'd0);
      #2 reset_n = 1'b1;
      repeat (12) tick();
      check("rst_busy_after", {31'b0, bus.Busy}, 32'd0);
      check("rst_hi_after", bus.HI, 32'd0);
      check("rst_lo_after", bus.LO, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
